// File: rtl/pio_pkg.sv
// Shared constants for the debounced input PIO: register word addresses and
// reset values of the edge-enable registers.
package pio_pkg;

    typedef enum logic [2:0] {
        PIO_ADDR_DATA         = 3'd0,
        PIO_ADDR_RAW          = 3'd1,
        PIO_ADDR_IRQ_MASK     = 3'd2,
        PIO_ADDR_EDGE_CAPTURE = 3'd3,
        PIO_ADDR_RISE_EN      = 3'd4,
        PIO_ADDR_FALL_EN      = 3'd5
    } pio_addr_e;

    // Rising edges are reported out of reset, falling edges are not.
    localparam logic [31:0] PIO_RISE_EN_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] PIO_FALL_EN_RST = 32'h0000_0000;

endpackage : pio_pkg

// File: rtl/pio_debounce_bit.sv
// One input channel: two-flop synchroniser, hold-time debounce counter and
// the accepted level with its one-cycle delayed copy for edge detection.
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_sync2,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_d;

    // Synchroniser, debounce counter and accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync1    <= i_pin;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sync2  = r_sync2;
    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_d;
    assign o_fall   = ~r_stable & r_stable_d;

endmodule : pio_debounce_bit

// File: rtl/pio_in_debounced.sv
// Avalon-MM input PIO with per-channel debounce, selectable edge capture
// (write-1-to-clear) and a masked level interrupt.
module pio_in_debounced
    import pio_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [31:0]      r_readdata;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_ch
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_pin    (in_port[i]),
            .o_sync2  (w_sync2[i]),
            .o_stable (w_stable[i]),
            .o_rise   (w_rise[i]),
            .o_fall   (w_fall[i])
        );
    end

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;
    assign w_evt          = (w_rise & r_rise_en) | (w_fall & r_fall_en);

    // Write-1-to-clear mask for the capture register.
    always_comb begin
        w_clr = '0;
        if (w_wr && (address == PIO_ADDR_EDGE_CAPTURE)) begin
            w_clr = w_wdata;
        end else begin
            w_clr = '0;
        end
    end

    // Control registers; a new event takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_rise_en      <= PIO_RISE_EN_RST[WIDTH-1:0];
            r_fall_en      <= PIO_FALL_EN_RST[WIDTH-1:0];
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_evt;
            if (w_wr && (address == PIO_ADDR_IRQ_MASK)) begin
                r_irq_mask <= w_wdata;
            end
            if (w_wr && (address == PIO_ADDR_RISE_EN)) begin
                r_rise_en <= w_wdata;
            end
            if (w_wr && (address == PIO_ADDR_FALL_EN)) begin
                r_fall_en <= w_wdata;
            end
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (address)
            PIO_ADDR_DATA:         w_rdata = 32'(w_stable);
            PIO_ADDR_RAW:          w_rdata = 32'(w_sync2);
            PIO_ADDR_IRQ_MASK:     w_rdata = 32'(r_irq_mask);
            PIO_ADDR_EDGE_CAPTURE: w_rdata = 32'(r_edge_capture);
            PIO_ADDR_RISE_EN:      w_rdata = 32'(r_rise_en);
            PIO_ADDR_FALL_EN:      w_rdata = 32'(r_fall_en);
            default:               w_rdata = 32'h0000_0000;
        endcase
    end

    // Read data is refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0000_0000;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule : pio_in_debounced

// File: tb/tb_pio_in_debounced.sv
// Directed bench: a 10-bit / 8-cycle debounce instance for register and
// timing behaviour, and a 32-bit / unfiltered instance for the width corner.
module tb_pio_in_debounced;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [9:0]  in_port = 10'h000;
    logic [31:0] readdata;
    logic        irq;

    logic [2:0]  address2 = 3'd0;
    logic        chipselect2 = 1'b0;
    logic        write_n2 = 1'b1;
    logic [31:0] writedata2 = 32'h0;
    logic [31:0] in_port2 = 32'h0;
    logic [31:0] readdata2;
    logic        irq2;

    int n_checks = 0;
    int n_errors = 0;

    pio_in_debounced #(.WIDTH(10), .DEBOUNCE_CYCLES(8)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    pio_in_debounced #(.WIDTH(32), .DEBOUNCE_CYCLES(1)) u_dut_w32 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address2),
        .chipselect (chipselect2),
        .write_n    (write_n2),
        .writedata  (writedata2),
        .in_port    (in_port2),
        .readdata   (readdata2),
        .irq        (irq2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    logic [31:0] v;
    logic [31:0] rst_exp [0:5];

    initial begin
        rst_exp[0] = 32'h000; rst_exp[1] = 32'h000; rst_exp[2] = 32'h000;
        rst_exp[3] = 32'h000; rst_exp[4] = 32'h3FF; rst_exp[5] = 32'h000;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset asserted in the middle of a debounce count.
        in_port = 10'h001;
        repeat (5) tick();
        reset_n = 1'b0;
        #2;
        in_port = 10'h000;
        chk("irq_in_reset", {31'd0, irq}, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        for (int a = 0; a < 6; a++) begin
            rd(3'(a), v);
            chk($sformatf("reset_addr%0d", a), v, rst_exp[a]);
        end
        chk("reset_irq", {31'd0, irq}, 32'h0);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, v);
        chk("addr6_zero", v, 32'h0);
        wr(3'd0, 32'h0000_03FF);
        rd(3'd0, v);
        chk("data_ro", v, 32'h0);

        // Glitch shorter than the debounce window.
        in_port = 10'h008;
        repeat (5) tick();
        in_port = 10'h000;
        repeat (20) tick();
        rd(3'd0, v);
        chk("glitch_data", v, 32'h0);
        rd(3'd3, v);
        chk("glitch_cap", v, 32'h0);

        // Held rise: DATA lands at edge k+9, capture (seen on irq) at k+10.
        wr(3'd2, 32'h0000_0008);
        address = 3'd0;
        in_port = 10'h008;
        repeat (10) tick();
        chk("rise_data_early", readdata, 32'h0);
        chk("rise_irq_early", {31'd0, irq}, 32'h0);
        tick();
        chk("rise_data", readdata, 32'h008);
        chk("rise_irq", {31'd0, irq}, 32'h1);
        rd(3'd1, v);
        chk("raw", v, 32'h008);
        rd(3'd3, v);
        chk("rise_cap", v, 32'h008);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd2, 32'h0);
        rd(3'd3, v);
        chk("cap_cleared", v, 32'h0);

        // Falling edges only, on bit 0.
        wr(3'd5, 32'h001);
        wr(3'd4, 32'h000);
        in_port = 10'h009;
        repeat (20) tick();
        rd(3'd3, v);
        chk("rise_masked", v, 32'h0);
        in_port = 10'h008;
        repeat (20) tick();
        rd(3'd3, v);
        chk("fall_cap", v, 32'h001);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd4, 32'h3FF);
        wr(3'd5, 32'h000);

        // IRQ masking and write-1-to-clear.
        wr(3'd2, 32'h004);
        in_port = 10'h02C;
        repeat (20) tick();
        chk("irq_set", {31'd0, irq}, 32'h1);
        rd(3'd3, v);
        chk("cap_2_5", v, 32'h024);
        wr(3'd3, 32'h004);
        chk("irq_clr", {31'd0, irq}, 32'h0);
        rd(3'd3, v);
        chk("w1c_bit2", v, 32'h020);

        // Clear of bit 1 on the same edge its capture is set: set wins.
        in_port = 10'h02E;
        repeat (10) tick();
        address    = 3'd3;
        writedata  = 32'h002;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd3, v);
        chk("set_beats_clr", v, 32'h022);
        wr(3'd3, 32'h002);
        rd(3'd3, v);
        chk("w1c_bit1", v, 32'h020);

        // 32-bit, no filtering: RAW at k+2, DATA at k+2, capture at k+3.
        address2 = 3'd1;
        in_port2 = 32'hFFFF_FFFF;
        repeat (2) tick();
        chk("w32_raw_early", readdata2, 32'h0);
        tick();
        chk("w32_raw", readdata2, 32'hFFFF_FFFF);
        address2 = 3'd0;
        tick();
        chk("w32_data", readdata2, 32'hFFFF_FFFF);
        address2 = 3'd3;
        tick();
        chk("w32_cap", readdata2, 32'hFFFF_FFFF);
        chk("w32_irq_masked", {31'd0, irq2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pio_in_debounced
